// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared constants, FSM encoding and helpers for the iterative CORDIC engine
package cordic_pkg;

  // Operating mode as latched at accept.
  localparam logic CORDIC_MODE_ROT = 1'b0;
  localparam logic CORDIC_MODE_VEC = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cordic_state_e;

  localparam real CORDIC_PI = 3.14159265358979323846;

  // Angle code corresponding to pi/4 for a given angle width.
  function automatic real cordic_pi4_code(input int angle_width);
    return 2.0 ** (angle_width - 1);
  endfunction

  // Width of the iteration counter; never narrower than one bit.
  function automatic int cordic_cnt_width(input int iterations);
    return (iterations > 1) ? $clog2(iterations) : 1;
  endfunction

endpackage

// File: rtl/cordic_iter_engine_if.sv
// rtl/cordic_iter_engine_if.sv - input/output handshake bundle of the iterative CORDIC engine
interface cordic_iter_engine_if #(
  parameter int DATA_WIDTH  = 12,
  parameter int ANGLE_WIDTH = 16,
  parameter int TAG_WIDTH   = 2
);
  logic                          in_valid;
  logic                          in_ready;
  logic                          mode_i;
  logic signed [DATA_WIDTH:0]    x_i;
  logic signed [DATA_WIDTH:0]    y_i;
  logic signed [ANGLE_WIDTH:0]   z_i;
  logic        [TAG_WIDTH-1:0]   tag_i;
  logic                          out_valid;
  logic                          out_ready;
  logic signed [DATA_WIDTH:0]    x_o;
  logic signed [DATA_WIDTH:0]    y_o;
  logic signed [ANGLE_WIDTH:0]   z_o;
  logic        [TAG_WIDTH-1:0]   tag_o;

  // Producer/consumer side (drives operands, accepts results).
  modport master (
    output in_valid, mode_i, x_i, y_i, z_i, tag_i, out_ready,
    input  in_ready, out_valid, x_o, y_o, z_o, tag_o
  );

  // Engine side.
  modport slave (
    input  in_valid, mode_i, x_i, y_i, z_i, tag_i, out_ready,
    output in_ready, out_valid, x_o, y_o, z_o, tag_o
  );
endinterface

// File: rtl/cordic_atan_rom.sv
// rtl/cordic_atan_rom.sv - elaboration-built arctangent table indexed by iteration
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int ANGLE_WIDTH = 16,
  parameter int ITERATIONS  = 14,
  localparam int IDX_W      = cordic_cnt_width(ITERATIONS)
) (
  input  logic [IDX_W-1:0]        idx,
  output logic signed [ANGLE_WIDTH:0] atan_o
);

  logic signed [ANGLE_WIDTH:0] atan_tab [ITERATIONS];

  // Entry i = round(pi/4-code * (4/pi) * atan(2^-i)), fixed at elaboration.
  for (genvar g = 0; g < ITERATIONS; g++) begin : g_entry
    localparam real ANGLE_RAD = $atan(1.0 / (2.0 ** g));
    localparam int  CODE      = $rtoi(ANGLE_RAD * 4.0 / CORDIC_PI * cordic_pi4_code(ANGLE_WIDTH) + 0.5);
    assign atan_tab[g] = (ANGLE_WIDTH+1)'(CODE);
  end

  // Explicit compare-select so out-of-range counter values read as zero.
  always_comb begin
    atan_o = '0;
    for (int k = 0; k < ITERATIONS; k++) begin
      if (idx == IDX_W'(k)) atan_o = atan_tab[k];
    end
  end

endmodule

// File: rtl/cordic_iter_engine.sv
// rtl/cordic_iter_engine.sv - iterative CORDIC, one micro-rotation per clock on a shared datapath
module cordic_iter_engine
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH  = 12,
  parameter int ANGLE_WIDTH = 16,
  parameter int ITERATIONS  = 14,
  parameter int TAG_WIDTH   = 2
) (
  input logic            clk,
  input logic            rst,
  cordic_iter_engine_if.slave bus
);

  localparam int CW = cordic_cnt_width(ITERATIONS);

  cordic_state_e               state_q, state_d;
  logic [CW-1:0]               iter_q;
  logic signed [DATA_WIDTH:0]  x_q, y_q, sx, sy;
  logic signed [ANGLE_WIDTH:0] z_q, atan_v;
  logic                        mode_q;
  logic [TAG_WIDTH-1:0]        tag_q;
  logic                        accept, last_iter, d_pos;

  cordic_atan_rom #(
    .ANGLE_WIDTH (ANGLE_WIDTH),
    .ITERATIONS  (ITERATIONS)
  ) u_atan_rom (
    .idx    (iter_q),
    .atan_o (atan_v)
  );

  assign accept    = (state_q == IDLE) && bus.in_valid;
  assign last_iter = (iter_q == CW'(ITERATIONS - 1));
  assign sx        = x_q >>> iter_q;
  assign sy        = y_q >>> iter_q;

  // Rotation steers z towards zero (z == 0 rotates negative); vectoring steers y towards zero.
  assign d_pos = (mode_q == CORDIC_MODE_VEC) ? y_q[DATA_WIDTH]
                                             : (!z_q[ANGLE_WIDTH] && (z_q != '0));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = RUN;
      end
      RUN: begin
        if (last_iter) state_d = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture at accept, then one simultaneous x/y/z micro-rotation per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      mode_q <= CORDIC_MODE_ROT;
      tag_q  <= '0;
      iter_q <= '0;
    end else if (accept) begin
      x_q    <= bus.x_i;
      y_q    <= bus.y_i;
      z_q    <= bus.z_i;
      mode_q <= bus.mode_i;
      tag_q  <= bus.tag_i;
      iter_q <= '0;
    end else if (state_q == RUN) begin
      if (d_pos) begin
        x_q <= x_q - sy;
        y_q <= y_q + sx;
        z_q <= z_q - atan_v;
      end else begin
        x_q <= x_q + sy;
        y_q <= y_q - sx;
        z_q <= z_q + atan_v;
      end
      iter_q <= last_iter ? '0 : iter_q + CW'(1);
    end
  end

  // Working registers hold the final result throughout DONE.
  assign bus.x_o   = x_q;
  assign bus.y_o   = y_q;
  assign bus.z_o   = z_q;
  assign bus.tag_o = tag_q;

endmodule
